// File: rtl/countdown_ctrl_pkg.sv
// Shared constants for the countdown control block: FSM state encoding and
// the default counter width.
package countdown_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int WIDTH_DEFAULT = 6;

    // True when a countdown of this value finishes on the next enabled edge.
    function automatic logic is_last(input logic [31:0] value);
        return value == 32'd1;
    endfunction

endpackage

// File: rtl/countdown_ctrl_dcount_core.sv
// Falling-edge down counter built from T flip-flop cells with parallel load
// and asynchronous reset.
module tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic ld,
    input  logic d,
    input  logic t,
    output logic q
);

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            q <= 1'b0;
        end else if (ld) begin
            q <= d;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

module dcount_core #(
    parameter int WIDTH = countdown_ctrl_pkg::WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             dec,
    output logic [WIDTH-1:0] q
);

    // zlow[i] is high when every bit below i is zero, i.e. bit i borrows.
    logic [WIDTH-1:0] zlow;
    logic [WIDTH-1:0] tog;
    logic             nonzero;

    assign zlow[0] = 1'b1;
    assign nonzero = |q;

    genvar i;
    generate
        for (i = 1; i < WIDTH; i++) begin : g_chain
            assign zlow[i] = zlow[i-1] & ~q[i-1];
        end
        for (i = 0; i < WIDTH; i++) begin : g_bit
            // Gating with nonzero keeps the counter from wrapping below 0.
            assign tog[i] = dec & nonzero & zlow[i];
            tff_cell u_tff (
                .clk   (clk),
                .reset (reset),
                .ld    (ld),
                .d     (d[i]),
                .t     (tog[i]),
                .q     (q[i])
            );
        end
    endgenerate

endmodule

// File: rtl/countdown_ctrl.sv
// Loadable countdown controller: IDLE/RUN FSM on the falling clock edge that
// drives a down counter and reports busy and a one-cycle done pulse.
module countdown_ctrl
    import countdown_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    state_t state;
    logic   dec;
    logic   load_zero;

    assign load_zero = (load_val == '0);

    // Load takes priority; the counter only moves while running.
    assign dec = (state == RUN) && enable && !load;

    dcount_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .reset (reset),
        .ld    (load),
        .d     (load_val),
        .dec   (dec),
        .q     (count)
    );

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                // A restart in RUN silently drops the old countdown.
                if (load_zero) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    state <= RUN;
                    busy  <= 1'b1;
                end
            end else if (state == RUN && enable && is_last(32'(count))) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Self-checking bench for countdown_ctrl: directed scenarios plus random
// traffic compared against a behavioural model of the countdown.
module tb_countdown_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [5:0] load_val;
    logic       enable;
    logic [5:0] count;
    logic       busy;
    logic       done;

    int  m_count;
    bit  m_run;
    bit  m_done;
    int  nchk = 0;
    int  nerr = 0;

    countdown_ctrl #(.WIDTH(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .enable   (enable),
        .count    (count),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            m_count = 0;
            m_run   = 0;
            m_done  = 0;
        end else begin
            m_done = 0;
            if (load) begin
                m_count = int'(load_val);
                m_run   = (load_val != 0);
                m_done  = (load_val == 0);
            end else if (m_run && enable) begin
                m_count = m_count - 1;
                if (m_count == 0) begin
                    m_run  = 0;
                    m_done = 1;
                end
            end
        end
    endtask

    // One clock: drive at rising edge, DUT acts on falling edge, check 1 ns later.
    task automatic cyc(input bit r, input bit l, input int lv, input bit en, input string tag);
        @(posedge clk);
        reset    = r;
        load     = l;
        load_val = lv[5:0];
        enable   = en;
        @(negedge clk);
        model_edge();
        #1;
        check({tag, ".count"}, 32'(count), 32'(m_count));
        check({tag, ".busy"},  32'(busy),  32'(m_run));
        check({tag, ".done"},  32'(done),  32'(m_done));
    endtask

    int exp_seq [6];
    bit en_seq  [6];
    int dones;
    int wrapped;

    initial begin
        reset = 1'b1; load = 1'b0; load_val = '0; enable = 1'b0;
        m_count = 0; m_run = 0; m_done = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst.count", 32'(count), 32'd0);
        check("rst.busy",  32'(busy),  32'd0);
        check("rst.done",  32'(done),  32'd0);
        cyc(1, 1, 7, 1, "rst_ignore");
        check("rst_ignore.c0", 32'(count), 32'd0);

        // Basic countdown from 5
        cyc(0, 1, 5, 1, "basic_ld");
        check("basic_ld.c", 32'(count), 32'd5);
        for (int k = 1; k <= 5; k++) begin
            cyc(0, 0, 0, 1, "basic");
            check("basic.seq",  32'(count), 32'(5 - k));
            check("basic.dn",   32'(done),  32'(k == 5));
            check("basic.bz",   32'(busy),  32'(k < 5));
        end
        cyc(0, 0, 0, 1, "basic_after");
        check("basic_after.dn", 32'(done), 32'd0);

        // Pause
        exp_seq = '{3, 3, 3, 2, 1, 0};
        en_seq  = '{1, 0, 0, 1, 1, 1};
        cyc(0, 1, 4, 0, "pause_ld");
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 0, en_seq[k], "pause");
            check("pause.seq", 32'(count), 32'(exp_seq[k]));
            dones += int'(done);
        end
        cyc(0, 0, 0, 0, "pause_after");
        dones += int'(done);
        check("pause.ndone", 32'(dones), 32'd1);

        // Zero load
        cyc(0, 1, 0, 1, "zero");
        check("zero.dn", 32'(done), 32'd1);
        check("zero.bz", 32'(busy), 32'd0);
        cyc(0, 0, 0, 1, "zero_after");
        check("zero_after.dn", 32'(done), 32'd0);

        // Max load
        cyc(0, 1, 63, 1, "max_ld");
        dones = 0; wrapped = 0;
        for (int k = 1; k <= 63; k++) begin
            cyc(0, 0, 0, 1, "max");
            if (count == 6'd63) wrapped++;
            dones += int'(done);
        end
        check("max.done_at_63", 32'(done), 32'd1);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 1, "max_after");
            if (count == 6'd63) wrapped++;
            dones += int'(done);
        end
        check("max.wrap", 32'(wrapped), 32'd0);
        check("max.ndone", 32'(dones), 32'd1);

        // Restart mid-countdown
        cyc(0, 1, 8, 1, "rs_ld8");
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, "rs_dec");
        check("rs.c5", 32'(count), 32'd5);
        cyc(0, 1, 2, 1, "rs_ld2");
        check("rs.c2", 32'(count), 32'd2);
        dones = 0;
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 1, "rs");
            dones += int'(done);
        end
        check("rs.ndone", 32'(dones), 32'd1);

        // Idle immunity
        for (int k = 0; k < 10; k++) begin
            cyc(0, 0, 0, 1, "idle");
            check("idle.c", 32'(count), 32'd0);
            check("idle.dn", 32'(done), 32'd0);
        end

        // Asynchronous reset mid-run
        cyc(0, 1, 10, 1, "ar_ld");
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1, "ar_dec");
        check("ar.c6", 32'(count), 32'd6);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        m_count = 0; m_run = 0; m_done = 0;
        check("ar.imm_count", 32'(count), 32'd0);
        check("ar.imm_busy",  32'(busy),  32'd0);
        check("ar.imm_done",  32'(done),  32'd0);
        cyc(1, 0, 0, 1, "ar_hold");
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 0, 1, "ar_post");
            check("ar_post.c", 32'(count), 32'd0);
            dones += int'(done);
        end
        check("ar.ndone", 32'(dones), 32'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            bit r, l, en;
            int lv;
            r  = ($urandom_range(0, 99) == 0);
            l  = ($urandom_range(0, 9) == 0);
            en = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       lv = 0;
                1:       lv = 63;
                default: lv = $urandom_range(1, 12);
            endcase
            cyc(r, l, lv, en, "rand");
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
